// File: rtl/tmds_multi_encoder_if.sv
// Parallel pixel-side bus of the N-channel TMDS encoder: mode, per-channel payload and symbols.
// Streaming bus: one symbol in and one symbol out on every pixclk cycle, with no valid/ready or backpressure.
interface tmds_multi_encoder_if #(
    parameter int NUM_CH = 3
);
    logic [2:0]          mode;
    logic [8*NUM_CH-1:0] vd;
    logic [2*NUM_CH-1:0] cd;
    logic [4*NUM_CH-1:0] aux;
    logic [10*NUM_CH-1:0] tmds;

    modport master (output mode, vd, cd, aux, input tmds);
    modport slave  (input mode, vd, cd, aux, output tmds);
endinterface

// File: rtl/tmds_multi_encoder.sv
// N-channel TMDS encoder (control, 8b/10b video, guard bands, TERC4) with two register stages
// and an independent running disparity per channel.
module tmds_multi_encoder #(
    parameter int NUM_CH = 3,
    parameter int DISP_W = 5
) (
    input  logic pixclk,
    input  logic rst,
    tmds_multi_encoder_if.slave bus
);
    typedef enum logic [2:0] {
        MODE_CTRL  = 3'd0,
        MODE_VIDEO = 3'd1,
        MODE_VGB   = 3'd2,
        MODE_TERC4 = 3'd3,
        MODE_DGB   = 3'd4
    } mode_t;

    typedef logic signed [DISP_W-1:0] disp_t;

    localparam logic [9:0] SYM_CTRL0 = 10'h354;
    localparam disp_t DISP_ZERO = disp_t'(0);
    localparam disp_t DISP_TWO  = disp_t'(2);

    // Transition-minimising stage: XOR/XNOR chain, bit 8 flags the XOR variant.
    function automatic logic [8:0] min_transition(input logic [7:0] d);
        int n1;
        logic use_xnor;
        logic [8:0] q;
        n1 = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && !d[0]);
        q = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] a);
        logic [9:0] s;
        case (a)
            4'h0: s = 10'h29C;  4'h1: s = 10'h263;  4'h2: s = 10'h2E4;  4'h3: s = 10'h2E2;
            4'h4: s = 10'h171;  4'h5: s = 10'h11E;  4'h6: s = 10'h18E;  4'h7: s = 10'h13C;
            4'h8: s = 10'h2CC;  4'h9: s = 10'h139;  4'hA: s = 10'h19C;  4'hB: s = 10'h2C6;
            4'hC: s = 10'h28E;  4'hD: s = 10'h271;  4'hE: s = 10'h163;  default: s = 10'h2C3;
        endcase
        return s;
    endfunction

    // DC-balancing stage: returns {symbol, updated disparity}.
    function automatic logic [DISP_W+9:0] video_enc(input logic [8:0] qm, input disp_t d);
        int n1;
        disp_t bal;
        disp_t dn;
        logic [9:0] sym;
        n1 = $countones(qm[7:0]);
        bal = disp_t'(2 * n1 - 8);
        if (d == DISP_ZERO || bal == DISP_ZERO) begin
            if (qm[8]) begin
                sym = {2'b01, qm[7:0]};
                dn  = d + bal;
            end else begin
                sym = {2'b10, ~qm[7:0]};
                dn  = d - bal;
            end
        end else if (d[DISP_W-1] == bal[DISP_W-1]) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            dn  = d - bal + (qm[8] ? DISP_TWO : DISP_ZERO);
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            dn  = d + bal - (qm[8] ? DISP_ZERO : DISP_TWO);
        end
        return {sym, dn};
    endfunction

    mode_t in_mode;
    mode_t s1_mode;
    logic [8:0] s1_qm  [NUM_CH];
    logic [1:0] s1_cd  [NUM_CH];
    logic [3:0] s1_aux [NUM_CH];

    logic [9:0] sym_next  [NUM_CH];
    disp_t      disp_next [NUM_CH];
    disp_t      disp      [NUM_CH];
    logic [10*NUM_CH-1:0] tmds_q;

    // Reserved mode codes collapse to CTRL before they reach the pipeline.
    always_comb begin
        case (bus.mode)
            3'd1:    in_mode = MODE_VIDEO;
            3'd2:    in_mode = MODE_VGB;
            3'd3:    in_mode = MODE_TERC4;
            3'd4:    in_mode = MODE_DGB;
            default: in_mode = MODE_CTRL;
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            s1_mode <= MODE_CTRL;
            for (int c = 0; c < NUM_CH; c++) begin
                s1_qm[c]  <= '0;
                s1_cd[c]  <= '0;
                s1_aux[c] <= '0;
            end
        end else begin
            s1_mode <= in_mode;
            for (int c = 0; c < NUM_CH; c++) begin
                s1_qm[c]  <= min_transition(bus.vd[8*c +: 8]);
                s1_cd[c]  <= bus.cd[2*c +: 2];
                s1_aux[c] <= bus.aux[4*c +: 4];
            end
        end
    end

    // Every non-video symbol clears the disparity so the next video period starts balanced.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            sym_next[c]  = SYM_CTRL0;
            disp_next[c] = DISP_ZERO;
            case (s1_mode)
                MODE_VIDEO: {sym_next[c], disp_next[c]} = video_enc(s1_qm[c], disp[c]);
                MODE_VGB:   sym_next[c] = (c % 3 == 1) ? 10'h133 : 10'h2CC;
                MODE_TERC4: sym_next[c] = terc4_sym(s1_aux[c]);
                MODE_DGB:   sym_next[c] = (c == 0) ? terc4_sym(s1_aux[0]) : 10'h133;
                default:    sym_next[c] = ctrl_sym(s1_cd[c]);
            endcase
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tmds_q[10*c +: 10] <= SYM_CTRL0;
                disp[c]            <= DISP_ZERO;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                tmds_q[10*c +: 10] <= sym_next[c];
                disp[c]            <= disp_next[c];
            end
        end
    end

    assign bus.tmds = tmds_q;

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Bench for tmds_multi_encoder: 3- and 4-channel instances driven with identical per-channel data,
// checked against a behavioural TMDS model and against directed symbol constants.
module tb_tmds_multi_encoder;

    // clock / reset
    logic pixclk = 1'b0;
    logic rst;
    always #5 pixclk = ~pixclk;

    tmds_multi_encoder_if #(.NUM_CH(3)) if3 ();
    tmds_multi_encoder_if #(.NUM_CH(4)) if4 ();

    tmds_multi_encoder #(.NUM_CH(3), .DISP_W(5)) dut3 (.pixclk(pixclk), .rst(rst), .bus(if3));
    tmds_multi_encoder #(.NUM_CH(4), .DISP_W(5)) dut4 (.pixclk(pixclk), .rst(rst), .bus(if4));

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];

    logic [9:0] terc_tab [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                                  10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
    logic [9:0] ctrl_tab [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    // reference model state: sampled inputs awaiting encoding, running disparity per channel
    int          md [4];
    logic [2:0]  p_mode;
    logic [31:0] p_vd;
    logic [7:0]  p_cd;
    logic [15:0] p_aux;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Encodes the pending sample with the DVI rules written over ones/zeros counts.
    task automatic model_encode(output logic [39:0] o);
        o = '0;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] d;
            logic [7:0] q;
            logic [9:0] s;
            int n1, q8, ones, zeros;
            bit xn;
            s = 10'h354;
            if (p_mode == 3'd1) begin
                d  = p_vd[8*c +: 8];
                n1 = $countones(d);
                xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
                // q[i] is the parity of d[i:0], flipped on odd i when the XNOR chain is used
                for (int i = 0; i < 8; i++) begin
                    logic [7:0] mask;
                    mask = 8'((1 << (i + 1)) - 1);
                    q[i] = (($countones(d & mask) + (xn ? i : 0)) % 2) == 1;
                end
                q8    = xn ? 0 : 1;
                ones  = $countones(q);
                zeros = 8 - ones;
                if (md[c] == 0 || ones == zeros) begin
                    if (q8 == 1) begin
                        s = {2'b01, q};
                        md[c] += ones - zeros;
                    end else begin
                        s = {2'b10, ~q};
                        md[c] += zeros - ones;
                    end
                end else if ((md[c] > 0 && ones > zeros) || (md[c] < 0 && zeros > ones)) begin
                    s = {1'b1, q8[0], ~q};
                    md[c] += 2 * q8 + zeros - ones;
                end else begin
                    s = {1'b0, q8[0], q};
                    md[c] += ones - zeros - 2 * (1 - q8);
                end
            end else begin
                md[c] = 0;
                case (p_mode)
                    3'd2:    s = (c % 3 == 1) ? 10'h133 : 10'h2CC;
                    3'd3:    s = terc_tab[p_aux[4*c +: 4]];
                    3'd4:    s = (c == 0) ? terc_tab[p_aux[3:0]] : 10'h133;
                    default: s = ctrl_tab[p_cd[2*c +: 2]];
                endcase
            end
            o[10*c +: 10] = s;
        end
    endtask

    // driver: apply one cycle of inputs, advance the model, clock, compare both instances
    task automatic step(input logic r, input logic [2:0] m, input logic [31:0] v,
                        input logic [7:0] c, input logic [15:0] a);
        logic [39:0] e;
        logic [39:0] got;
        rst      = r;
        if3.mode = m;  if3.vd = v[23:0]; if3.cd = c[5:0]; if3.aux = a[11:0];
        if4.mode = m;  if4.vd = v;       if4.cd = c;      if4.aux = a;
        if (r) begin
            e = {4{10'h354}};
            for (int i = 0; i < 4; i++) md[i] = 0;
            p_mode = 3'd0; p_vd = '0; p_cd = '0; p_aux = '0;
        end else begin
            model_encode(e);
            p_mode = m; p_vd = v; p_cd = c; p_aux = a;
        end
        exp_q.push_back(e);
        @(posedge pixclk);
        #1;
        got = exp_q.pop_front();
        chk("model_ch0to3", if4.tmds, got);
        chk("model_ch0to2", {10'b0, if3.tmds}, {10'b0, got[29:0]});
    endtask

    logic [31:0] rv;
    logic [2:0]  rm;

    initial begin
        // 1: reset held 3 cycles, then CTRL / cd 00
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd0, 32'h0, 8'h00, 16'h0);
            chk("reset_354", if4.tmds, {4{10'h354}});
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 3'd0, 32'h0, 8'h00, 16'h0);
            chk("ctrl_after_reset", if4.tmds, {4{10'h354}});
        end

        // 2: three 0x00 video words from D = 0
        step(1'b0, 3'd1, 32'h0, 8'h00, 16'h0);
        step(1'b0, 3'd1, 32'h0, 8'h00, 16'h0);
        chk("vid00_first", {30'b0, if4.tmds[9:0]}, 40'h100);
        step(1'b0, 3'd1, 32'h0, 8'h00, 16'h0);
        chk("vid00_second", {30'b0, if4.tmds[9:0]}, 40'h3FF);
        step(1'b0, 3'd0, 32'h0, 8'h00, 16'h0);
        chk("vid00_third", {30'b0, if4.tmds[9:0]}, 40'h100);
        step(1'b0, 3'd0, 32'h0, 8'h00, 16'h0);

        // 3: 0xFF video then CTRL cd 01; next video must restart from D = 0
        step(1'b0, 3'd1, 32'hFFFF_FFFF, 8'h00, 16'h0);
        step(1'b0, 3'd0, 32'h0, 8'h55, 16'h0);
        chk("vidFF", if4.tmds, {4{10'h200}});
        step(1'b0, 3'd1, 32'h0, 8'h55, 16'h0);
        chk("ctrl01", if4.tmds, {4{10'h0AB}});
        step(1'b0, 3'd0, 32'h0, 8'h00, 16'h0);
        chk("video_restart_d0", {30'b0, if4.tmds[9:0]}, 40'h100);

        // 4: TERC4 sweep, then reserved mode 7 behaves as CTRL
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 3'd3, 32'h0, 8'h00, {4{i[3:0]}});
            if (i > 0) chk("terc4_sweep", if4.tmds, {4{terc_tab[i-1]}});
        end
        step(1'b0, 3'd7, 32'h0, 8'hFF, 16'h0);
        chk("terc4_last", if4.tmds, {4{terc_tab[15]}});
        step(1'b0, 3'd0, 32'h0, 8'h00, 16'h0);
        chk("mode7_ctrl", if4.tmds, {4{10'h2AB}});

        // 5: CTRL, VGB x2, VIDEO, DGB
        step(1'b0, 3'd0, 32'h0, 8'h00, 16'h0);
        step(1'b0, 3'd2, 32'h0, 8'h00, 16'h0);
        step(1'b0, 3'd2, 32'h0, 8'h00, 16'h0);
        chk("vgb_first", if4.tmds, {10'h2CC, 10'h2CC, 10'h133, 10'h2CC});
        step(1'b0, 3'd1, 32'h1234_5678, 8'h00, 16'h0);
        chk("vgb_second", if4.tmds, {10'h2CC, 10'h2CC, 10'h133, 10'h2CC});
        step(1'b0, 3'd4, 32'h0, 8'h00, 16'h000C);
        step(1'b0, 3'd0, 32'h0, 8'h00, 16'h0);
        chk("dgb", if4.tmds, {10'h133, 10'h133, 10'h133, 10'h28E});

        // reset asserted in the middle of a video run
        for (int i = 0; i < 4; i++) step(1'b0, 3'd1, $urandom, 8'h00, 16'h0);
        step(1'b1, 3'd1, $urandom, 8'h00, 16'h0);
        chk("midvideo_reset", if4.tmds, {4{10'h354}});
        step(1'b0, 3'd1, $urandom, 8'h00, 16'h0);
        chk("midvideo_reset_flush", if4.tmds, {4{10'h354}});

        // 6: random modes and data, video-weighted, with occasional reset
        for (int n = 0; n < 10000; n++) begin
            rv = $urandom;
            rm = ($urandom_range(0, 9) < 5) ? 3'd1 : 3'($urandom_range(0, 7));
            step(($urandom_range(0, 499) == 0), rm, rv, 8'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
